// File: rtl/alu_driver_pkg.sv
// Shared types and constants for the Hack-style 4-bit ALU driver:
// opcodes, ALU control words, alu_out field positions, jump mask bits and FSM states.
package alu_driver_pkg;

    typedef enum logic [4:0] {
        OP_ZERO  = 5'd0,
        OP_ONE   = 5'd1,
        OP_NEG1  = 5'd2,
        OP_X     = 5'd3,
        OP_Y     = 5'd4,
        OP_NOTX  = 5'd5,
        OP_NOTY  = 5'd6,
        OP_NEGX  = 5'd7,
        OP_NEGY  = 5'd8,
        OP_XP1   = 5'd9,
        OP_YP1   = 5'd10,
        OP_XM1   = 5'd11,
        OP_YM1   = 5'd12,
        OP_ADD   = 5'd13,
        OP_XSUBY = 5'd14,
        OP_YSUBX = 5'd15,
        OP_AND   = 5'd16,
        OP_OR    = 5'd17,
        OP_MUL   = 5'd18
    } op_e;

    // Control word layout {no,f,ny,zy,nx,zx}
    localparam logic [5:0] CTRL_ZERO  = 6'h15;
    localparam logic [5:0] CTRL_ONE   = 6'h3F;
    localparam logic [5:0] CTRL_NEG1  = 6'h17;
    localparam logic [5:0] CTRL_X     = 6'h0C;
    localparam logic [5:0] CTRL_Y     = 6'h03;
    localparam logic [5:0] CTRL_NOTX  = 6'h2C;
    localparam logic [5:0] CTRL_NOTY  = 6'h23;
    localparam logic [5:0] CTRL_NEGX  = 6'h3C;
    localparam logic [5:0] CTRL_NEGY  = 6'h33;
    localparam logic [5:0] CTRL_XP1   = 6'h3E;
    localparam logic [5:0] CTRL_YP1   = 6'h3B;
    localparam logic [5:0] CTRL_XM1   = 6'h1C;
    localparam logic [5:0] CTRL_YM1   = 6'h13;
    localparam logic [5:0] CTRL_ADD   = 6'h10;
    localparam logic [5:0] CTRL_XSUBY = 6'h32;
    localparam logic [5:0] CTRL_YSUBX = 6'h38;
    localparam logic [5:0] CTRL_AND   = 6'h00;
    localparam logic [5:0] CTRL_OR    = 6'h2A;

    localparam int RES_MSB = 3;
    localparam int ZR_BIT  = 4;
    localparam int NG_BIT  = 5;

    localparam int JMP_LT = 2;
    localparam int JMP_EQ = 1;
    localparam int JMP_GT = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    function automatic logic jump_eval(input logic [2:0] mask, input logic zr, input logic ng);
        return (mask[JMP_LT] & ng) | (mask[JMP_EQ] & zr) | (mask[JMP_GT] & ~ng & ~zr);
    endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational opcode decoder: maps a mnemonic opcode to the ALU control word
// and flags whether it is legal and whether it is the multi-cycle MUL.
module alu_ctrl_decode
    import alu_driver_pkg::*;
(
    input  logic [4:0] op,
    output logic [5:0] ctrl,
    output logic       legal,
    output logic       is_mul
);

    always_comb begin
        ctrl   = CTRL_ZERO;
        legal  = 1'b1;
        is_mul = 1'b0;
        case (op_e'(op))
            OP_ZERO:  ctrl = CTRL_ZERO;
            OP_ONE:   ctrl = CTRL_ONE;
            OP_NEG1:  ctrl = CTRL_NEG1;
            OP_X:     ctrl = CTRL_X;
            OP_Y:     ctrl = CTRL_Y;
            OP_NOTX:  ctrl = CTRL_NOTX;
            OP_NOTY:  ctrl = CTRL_NOTY;
            OP_NEGX:  ctrl = CTRL_NEGX;
            OP_NEGY:  ctrl = CTRL_NEGY;
            OP_XP1:   ctrl = CTRL_XP1;
            OP_YP1:   ctrl = CTRL_YP1;
            OP_XM1:   ctrl = CTRL_XM1;
            OP_YM1:   ctrl = CTRL_YM1;
            OP_ADD:   ctrl = CTRL_ADD;
            OP_XSUBY: ctrl = CTRL_XSUBY;
            OP_YSUBX: ctrl = CTRL_YSUBX;
            OP_AND:   ctrl = CTRL_AND;
            OP_OR:    ctrl = CTRL_OR;
            OP_MUL:   is_mul = 1'b1;
            default:  legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_driver.sv
// Command-side driver for a combinational Hack-style ALU: registers operands and
// control, captures result/flags, evaluates the jump condition, and sequences MUL by repeated adds.
module alu_driver
    import alu_driver_pkg::*;
#(
    parameter int W   = 4,
    parameter int OPW = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [OPW-1:0] cmd_op,
    input  logic [W-1:0]   cmd_x,
    input  logic [W-1:0]   cmd_y,
    input  logic [2:0]     cmd_jmp,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [W-1:0]   rsp_data,
    output logic           rsp_zr,
    output logic           rsp_ng,
    output logic           rsp_jump,
    output logic           rsp_err,
    output logic [W-1:0]   alu_x,
    output logic [W-1:0]   alu_y,
    output logic [5:0]     alu_ctrl,
    input  logic [W+1:0]   alu_out
);

    state_e       state_q, state_d;
    logic [W-1:0] alu_x_q, alu_x_d;
    logic [W-1:0] alu_y_q, alu_y_d;
    logic [5:0]   alu_ctrl_q, alu_ctrl_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] mx_q, mx_d;
    logic [2:0]   jmp_q, jmp_d;
    logic         err_pend_q, err_pend_d;
    logic [W-1:0] rsp_data_q, rsp_data_d;
    logic         rsp_zr_q, rsp_zr_d;
    logic         rsp_ng_q, rsp_ng_d;
    logic         rsp_jump_q, rsp_jump_d;
    logic         rsp_err_q, rsp_err_d;

    logic [5:0]   dec_ctrl;
    logic         dec_legal;
    logic         dec_is_mul;
    logic         capture;

    alu_ctrl_decode u_decode (
        .op     (cmd_op),
        .ctrl   (dec_ctrl),
        .legal  (dec_legal),
        .is_mul (dec_is_mul)
    );

    always_comb begin
        state_d    = state_q;
        alu_x_d    = alu_x_q;
        alu_y_d    = alu_y_q;
        alu_ctrl_d = alu_ctrl_q;
        cnt_d      = cnt_q;
        mx_d       = mx_q;
        jmp_d      = jmp_q;
        err_pend_d = err_pend_q;
        rsp_data_d = rsp_data_q;
        rsp_zr_d   = rsp_zr_q;
        rsp_ng_d   = rsp_ng_q;
        rsp_jump_d = rsp_jump_q;
        rsp_err_d  = rsp_err_q;
        capture    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    jmp_d      = cmd_jmp;
                    err_pend_d = ~dec_legal;
                    if (dec_is_mul) begin
                        alu_ctrl_d = CTRL_ZERO;
                        cnt_d      = cmd_y;
                        mx_d       = cmd_x;
                        state_d    = ST_MUL;
                    end else begin
                        // Illegal opcodes leave the ALU inputs untouched
                        if (dec_legal) begin
                            alu_x_d    = cmd_x;
                            alu_y_d    = cmd_y;
                            alu_ctrl_d = dec_ctrl;
                        end
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                capture = 1'b1;
                state_d = ST_RESP;
            end
            ST_MUL: begin
                if (cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    // Running sum feeds back through alu_x; the multiplicand is re-added each step
                    alu_x_d    = alu_out[RES_MSB:0];
                    alu_y_d    = mx_q;
                    alu_ctrl_d = CTRL_ADD;
                    cnt_d      = cnt_q - W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (capture) begin
            if (err_pend_q) begin
                rsp_data_d = '0;
                rsp_zr_d   = 1'b0;
                rsp_ng_d   = 1'b0;
                rsp_jump_d = 1'b0;
                rsp_err_d  = 1'b1;
            end else begin
                rsp_data_d = alu_out[RES_MSB:0];
                rsp_zr_d   = alu_out[ZR_BIT];
                rsp_ng_d   = alu_out[NG_BIT];
                rsp_jump_d = jump_eval(jmp_q, alu_out[ZR_BIT], alu_out[NG_BIT]);
                rsp_err_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            alu_x_q    <= '0;
            alu_y_q    <= '0;
            alu_ctrl_q <= CTRL_ZERO;
            cnt_q      <= '0;
            mx_q       <= '0;
            jmp_q      <= '0;
            err_pend_q <= 1'b0;
            rsp_data_q <= '0;
            rsp_zr_q   <= 1'b0;
            rsp_ng_q   <= 1'b0;
            rsp_jump_q <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            alu_x_q    <= alu_x_d;
            alu_y_q    <= alu_y_d;
            alu_ctrl_q <= alu_ctrl_d;
            cnt_q      <= cnt_d;
            mx_q       <= mx_d;
            jmp_q      <= jmp_d;
            err_pend_q <= err_pend_d;
            rsp_data_q <= rsp_data_d;
            rsp_zr_q   <= rsp_zr_d;
            rsp_ng_q   <= rsp_ng_d;
            rsp_jump_q <= rsp_jump_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_zr    = rsp_zr_q;
    assign rsp_ng    = rsp_ng_q;
    assign rsp_jump  = rsp_jump_q;
    assign rsp_err   = rsp_err_q;
    assign alu_x     = alu_x_q;
    assign alu_y     = alu_y_q;
    assign alu_ctrl  = alu_ctrl_q;

endmodule

// File: tb/tb_alu_driver.sv
// Directed bench for alu_driver with a behavioural Hack ALU as the alu_* partner.
// Handshake: a transfer happens on a rising edge where valid and ready are both high.
module tb_alu_driver;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [4:0] cmd_op;
    logic [3:0] cmd_x;
    logic [3:0] cmd_y;
    logic [2:0] cmd_jmp;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_data;
    logic       rsp_zr;
    logic       rsp_ng;
    logic       rsp_jump;
    logic       rsp_err;
    logic [3:0] alu_x;
    logic [3:0] alu_y;
    logic [5:0] alu_ctrl;
    logic [5:0] alu_out;

    int n_vec;
    int n_err;

    alu_driver dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_jmp   (cmd_jmp),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_zr    (rsp_zr),
        .rsp_ng    (rsp_ng),
        .rsp_jump  (rsp_jump),
        .rsp_err   (rsp_err),
        .alu_x     (alu_x),
        .alu_y     (alu_y),
        .alu_ctrl  (alu_ctrl),
        .alu_out   (alu_out)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational Hack ALU, control {no,f,ny,zy,nx,zx}
    logic [3:0] ax, ay, ares;
    always_comb begin
        ax = alu_ctrl[0] ? 4'h0 : alu_x;
        if (alu_ctrl[1]) ax = ~ax;
        ay = alu_ctrl[2] ? 4'h0 : alu_y;
        if (alu_ctrl[3]) ay = ~ay;
        ares = alu_ctrl[4] ? (ax + ay) : (ax & ay);
        if (alu_ctrl[5]) ares = ~ares;
    end
    assign alu_out = {ares[3], (ares == 4'h0), ares};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts and ends at a falling edge; the accept edge is the rising edge in between.
    task automatic send(input string tag, input logic [4:0] op, input logic [3:0] x,
                        input logic [3:0] y, input logic [2:0] j);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_x     = x;
        cmd_y     = y;
        cmd_jmp   = j;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 5'd0;
    endtask

    task automatic wait_rsp(input string tag, input int exp_lat);
        int lat;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic check_rsp(input string tag, input logic [3:0] d, input logic zr,
                             input logic ng, input logic jmp, input logic err);
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_data"},  32'(rsp_data),  32'(d));
        chk({tag, "_zr"},    32'(rsp_zr),    32'(zr));
        chk({tag, "_ng"},    32'(rsp_ng),    32'(ng));
        chk({tag, "_jump"},  32'(rsp_jump),  32'(jmp));
        chk({tag, "_err"},   32'(rsp_err),   32'(err));
    endtask

    task automatic take(input string tag);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, "_rsp_valid_after"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_cmd_ready_after"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 5'd0;
        cmd_x     = 4'd0;
        cmd_y     = 4'd0;
        cmd_jmp   = 3'd0;
        rsp_ready = 1'b0;

        // Reset values
        @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data",  32'(rsp_data),  32'd0);
        chk("rst_flags",     32'({rsp_zr, rsp_ng, rsp_jump, rsp_err}), 32'd0);
        chk("rst_alu_xy",    32'({alu_x, alu_y}), 32'd0);
        chk("rst_alu_ctrl",  32'(alu_ctrl), 32'h15);
        rst_n = 1'b1;
        @(negedge clk);

        // Async reset in the middle of MUL 3*9
        send("mulrst", 5'd18, 4'd3, 4'd9, 3'b000);
        repeat (3) @(negedge clk);
        chk("mulrst_busy", 32'(cmd_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("mulrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mulrst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("mulrst_alu_ctrl",  32'(alu_ctrl),  32'h15);
        chk("mulrst_alu_x",     32'(alu_x),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // XSUBY 3-5 = E, lt jump taken
        send("xsuby", 5'd14, 4'd3, 4'd5, 3'b100);
        chk("xsuby_alu_ctrl", 32'(alu_ctrl), 32'h32);
        chk("xsuby_alu_xy",   32'({alu_x, alu_y}), 32'h35);
        wait_rsp("xsuby", 1);
        check_rsp("xsuby", 4'hE, 1'b0, 1'b1, 1'b1, 1'b0);
        take("xsuby");

        // ADD 7+9 wraps to 0, eq jump taken
        send("add0", 5'd13, 4'd7, 4'd9, 3'b010);
        wait_rsp("add0", 1);
        check_rsp("add0", 4'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        take("add0");

        // OR 5|A = F, gt jump not taken on negative
        send("or", 5'd17, 4'd5, 4'hA, 3'b001);
        chk("or_alu_ctrl", 32'(alu_ctrl), 32'h2A);
        wait_rsp("or", 1);
        check_rsp("or", 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
        take("or");

        // MUL sequences
        send("mul35", 5'd18, 4'd3, 4'd5, 3'b000);
        wait_rsp("mul35", 6);
        check_rsp("mul35", 4'hF, 1'b0, 1'b1, 1'b0, 1'b0);
        take("mul35");

        send("mul54", 5'd18, 4'd5, 4'd4, 3'b001);
        wait_rsp("mul54", 5);
        check_rsp("mul54", 4'h4, 1'b0, 1'b0, 1'b1, 1'b0);
        take("mul54");

        send("mul70", 5'd18, 4'd7, 4'd0, 3'b010);
        wait_rsp("mul70", 1);
        check_rsp("mul70", 4'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        take("mul70");

        // Backpressure on ADD 1+1
        send("bp", 5'd13, 4'd1, 4'd1, 3'b001);
        wait_rsp("bp", 1);
        for (int i = 0; i < 3; i++) begin
            check_rsp("bp_hold", 4'h2, 1'b0, 1'b0, 1'b1, 1'b0);
            chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            @(negedge clk);
        end
        check_rsp("bp_last", 4'h2, 1'b0, 1'b0, 1'b1, 1'b0);
        take("bp");

        // Illegal opcode leaves ALU inputs as the ADD 1+1 left them
        send("ill", 5'd25, 4'd9, 4'd6, 3'b111);
        chk("ill_alu_ctrl", 32'(alu_ctrl), 32'h10);
        chk("ill_alu_xy",   32'({alu_x, alu_y}), 32'h11);
        wait_rsp("ill", 1);
        check_rsp("ill", 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("ill_alu_ctrl_resp", 32'(alu_ctrl), 32'h10);
        take("ill");

        // A legal op after the illegal one clears the error flag
        send("negx", 5'd7, 4'd2, 4'd0, 3'b100);
        chk("negx_alu_ctrl", 32'(alu_ctrl), 32'h3C);
        wait_rsp("negx", 1);
        check_rsp("negx", 4'hE, 1'b0, 1'b1, 1'b1, 1'b0);
        take("negx");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
